// File: rtl/cmp_accum_if.sv
// Result handshake between cmp_accum and the digital back end.
// master: producer side (cmp_accum); slave: consumer side (register bank / filter).
interface cmp_accum_if #(
   parameter int unsigned CW = 5
);
   logic [CW-1:0] code;
   logic          code_valid;
   logic          code_ready;
   logic          ovr;

   modport master (
      output code,
      output code_valid,
      output ovr,
      input  code_ready
   );

   modport slave (
      input  code,
      input  code_valid,
      input  ovr,
      output code_ready
   );
endinterface

// File: rtl/cmp_accum.sv
// Comparator decision accumulator.
// Synchronizes the raw comparator output, chopper-demodulates one decision per rising
// edge of sample, counts ones over a window of WINDOW decisions and offers the count
// as a code on a valid/ready handshake. A completed window that cannot be delivered
// is dropped and flagged with a one-cycle ovr pulse.
// Optional feature: define CMP_PHASE_CHK_EN to enable the sticky phase_err check
// (cmp_p1 == cmp_p2 at a strobe). Without it phase_err is tied to 0.
module cmp_accum #(
   parameter int unsigned WINDOW = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        cmp_p1,
   input  logic        cmp_p2,
   input  logic        sample,
   input  logic        cmp_out,
   cmp_accum_if.master out_if,
   output logic        phase_err
);

   localparam int unsigned CW = $clog2(WINDOW + 1);
   localparam int unsigned NW = $clog2(WINDOW);
   localparam logic [NW-1:0] LastIdx = NW'(WINDOW - 1);

   typedef enum logic [0:0] {StIdle, StAcc} state_e;

   state_e        state_q, state_d;
   logic          cmp_meta_q, cmp_s_q;
   logic          sample_q;
   logic [CW-1:0] acc_q, acc_d;
   logic [NW-1:0] n_q, n_d;
   logic [CW-1:0] code_q, code_d;
   logic          valid_q, valid_d;
   logic          ovr_q, ovr_d;

   logic          strobe;
   logic          dec;
   logic          complete;
   logic [CW-1:0] result;

   assign strobe = sample & ~sample_q;
   // p2 phase inverts the comparator polarity; undo it here
   assign dec    = cmp_s_q ^ cmp_p2;
   // acc_q never exceeds WINDOW-1 before the add, so the sum fits in CW bits
   assign result = acc_q + {{(CW - 1){1'b0}}, dec};

   // Synchronizer, sample edge detector and all state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmp_meta_q <= 1'b0;
         cmp_s_q    <= 1'b0;
         sample_q   <= 1'b0;
         state_q    <= StIdle;
         acc_q      <= '0;
         n_q        <= '0;
         code_q     <= '0;
         valid_q    <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         cmp_meta_q <= cmp_out;
         cmp_s_q    <= cmp_meta_q;
         sample_q   <= sample;
         state_q    <= state_d;
         acc_q      <= acc_d;
         n_q        <= n_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         ovr_q      <= ovr_d;
      end
   end

   // FSM next state and window accumulation
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      n_d      = n_q;
      complete = 1'b0;
      unique case (state_q)
         StIdle: begin
            // strobes ignored here; acc/n are already clear
            if (enable) begin
               state_d = StAcc;
            end
         end
         StAcc: begin
            if (!enable) begin
               // drop the partial window; IDLE wins over a coincident strobe
               state_d = StIdle;
               acc_d   = '0;
               n_d     = '0;
            end else if (strobe) begin
               if (n_q == LastIdx) begin
                  complete = 1'b1;
                  acc_d    = '0;
                  n_d      = '0;
               end else begin
                  acc_d = result;
                  n_d   = n_q + NW'(1);
               end
            end
         end
         default: begin
            state_d = StIdle;
            acc_d   = '0;
            n_d     = '0;
         end
      endcase
   end

   // Result handshake: load on free slot or same-cycle consume, else drop and flag
   always_comb begin
      code_d  = code_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (complete) begin
         if (!valid_q || out_if.code_ready) begin
            code_d  = result;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && out_if.code_ready) begin
         valid_d = 1'b0;
      end
   end

   assign out_if.code       = code_q;
   assign out_if.code_valid = valid_q;
   assign out_if.ovr        = ovr_q;

`ifdef CMP_PHASE_CHK_EN
   logic phase_err_q, phase_err_d;

   // Sticky flag: non-complementary phases seen at any strobe
   always_comb begin
      phase_err_d = phase_err_q;
      if (strobe && (cmp_p1 == cmp_p2)) begin
         phase_err_d = 1'b1;
      end
   end

   // Phase error flag register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_err_q <= 1'b0;
      end else begin
         phase_err_q <= phase_err_d;
      end
   end

   assign phase_err = phase_err_q;
`else
   logic unused_cmp_p1;
   assign unused_cmp_p1 = cmp_p1;
   assign phase_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_accum.sv
// Directed bench for cmp_accum (WINDOW=16): reset, demodulation, full-scale window,
// overrun/handshake, enable drop, reset mid-window and the optional phase check.
module tb_cmp_accum;

   logic clk;
   logic reset;
   logic enable;
   logic cmp_p1;
   logic cmp_p2;
   logic sample;
   logic cmp_out;
   logic phase_err;

   int n_checks;
   int n_errors;

   cmp_accum_if #(.CW(5)) out_if ();

   cmp_accum #(.WINDOW(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .cmp_p1    (cmp_p1),
      .cmp_p2    (cmp_p2),
      .sample    (sample),
      .cmp_out   (cmp_out),
      .out_if    (out_if),
      .phase_err (phase_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One decision: set phases/comparator, let the synchronizer settle, raise sample.
   // Returns at the negedge just after the strobe edge (sample still high).
   task automatic strobe(input logic p1, input logic p2, input logic cout, input logic rdy);
      @(negedge clk);
      sample            = 1'b0;
      out_if.code_ready = 1'b0;
      cmp_p1            = p1;
      cmp_p2            = p2;
      cmp_out           = cout;
      repeat (3) @(negedge clk);
      sample            = 1'b1;
      out_if.code_ready = rdy;
      @(negedge clk);
      out_if.code_ready = 1'b0;
   endtask

   // 16 decisions with alternating chopper phase; the first 'ones' decisions demodulate to 1
   task automatic run_window(input int ones, input logic rdy_last);
      for (int i = 0; i < 16; i++) begin
         logic p2;
         logic d;
         p2 = (i % 2) != 0;
         d  = i < ones;
         strobe(~p2, p2, d ? ~p2 : p2, (i == 15) ? rdy_last : 1'b0);
      end
   endtask

   task automatic consume();
      @(negedge clk);
      out_if.code_ready = 1'b1;
      @(negedge clk);
      out_if.code_ready = 1'b0;
   endtask

   initial begin
      n_checks          = 0;
      n_errors          = 0;
      reset             = 1'b1;
      enable            = 1'b0;
      cmp_p1            = 1'b1;
      cmp_p2            = 1'b0;
      sample            = 1'b0;
      cmp_out           = 1'b0;
      out_if.code_ready = 1'b0;

      // Reset held while inputs toggle
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         enable            = 1'b1;
         sample            = ~sample;
         cmp_out           = ~cmp_out;
         cmp_p1            = ~cmp_p1;
         cmp_p2            = ~cmp_p2;
         out_if.code_ready = ~out_if.code_ready;
      end
      check_eq("rst_code", 32'(out_if.code), 0);
      check_eq("rst_valid", 32'(out_if.code_valid), 0);
      check_eq("rst_ovr", 32'(out_if.ovr), 0);
      check_eq("rst_phase_err", 32'(phase_err), 0);
      @(negedge clk);
      enable            = 1'b0;
      sample            = 1'b0;
      out_if.code_ready = 1'b0;
      cmp_p1            = 1'b1;
      cmp_p2            = 1'b0;
      reset             = 1'b0;

      // cmp_out constant 1 with alternating phases: half the decisions are ones
      @(negedge clk);
      enable = 1'b1;
      for (int i = 0; i < 15; i++) begin
         logic p2;
         p2 = (i % 2) != 0;
         strobe(~p2, p2, 1'b1, 1'b0);
      end
      check_eq("pre_valid", 32'(out_if.code_valid), 0);
      strobe(1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("half_valid", 32'(out_if.code_valid), 1);
      check_eq("half_code", 32'(out_if.code), 8);
      check_eq("half_ovr", 32'(out_if.ovr), 0);
      consume();
      check_eq("consume_valid", 32'(out_if.code_valid), 0);
      check_eq("consume_code_held", 32'(out_if.code), 8);

      // All decisions zero
      run_window(0, 1'b0);
      check_eq("zero_code", 32'(out_if.code), 0);
      check_eq("zero_valid", 32'(out_if.code_valid), 1);
      consume();

      // Full scale, left unconsumed, then a second window overruns
      run_window(16, 1'b0);
      check_eq("full_code", 32'(out_if.code), 16);
      check_eq("full_valid", 32'(out_if.code_valid), 1);
      run_window(0, 1'b0);
      check_eq("ovr_pulse", 32'(out_if.ovr), 1);
      check_eq("ovr_code_kept", 32'(out_if.code), 16);
      check_eq("ovr_valid_kept", 32'(out_if.code_valid), 1);
      @(negedge clk);
      check_eq("ovr_one_cycle", 32'(out_if.ovr), 0);

      // Completion with ready in the same cycle replaces the pending code
      run_window(5, 1'b1);
      check_eq("swap_code", 32'(out_if.code), 5);
      check_eq("swap_valid", 32'(out_if.code_valid), 1);
      check_eq("swap_no_ovr", 32'(out_if.ovr), 0);
      consume();

      // Enable dropped mid-window discards the partial count
      for (int i = 0; i < 10; i++) begin
         logic p2;
         p2 = (i % 2) != 0;
         strobe(~p2, p2, ~p2, 1'b0);
      end
      @(negedge clk);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("drop_no_code", 32'(out_if.code_valid), 0);
      enable = 1'b1;
      run_window(3, 1'b0);
      check_eq("reen_code", 32'(out_if.code), 3);
      check_eq("reen_valid", 32'(out_if.code_valid), 1);
      consume();

      // Reset mid-window restarts the count
      for (int i = 0; i < 8; i++) begin
         logic p2;
         p2 = (i % 2) != 0;
         strobe(~p2, p2, ~p2, 1'b0);
      end
      @(negedge clk);
      reset  = 1'b1;
      sample = 1'b0;
      @(negedge clk);
      check_eq("midrst_valid", 32'(out_if.code_valid), 0);
      reset = 1'b0;
      run_window(2, 1'b0);
      check_eq("midrst_code", 32'(out_if.code), 2);
      consume();

      // Equal phases at one strobe: decision (cmp_s=0 ^ p2=1) still counts
      for (int i = 0; i < 16; i++) begin
         logic p2;
         p2 = (i % 2) != 0;
         if (i == 4) begin
            strobe(1'b1, 1'b1, 1'b0, 1'b0);
         end else begin
            strobe(~p2, p2, p2, 1'b0);
         end
      end
      check_eq("phase_code", 32'(out_if.code), 1);
`ifdef CMP_PHASE_CHK_EN
      check_eq("phase_err_set", 32'(phase_err), 1);
      repeat (5) @(negedge clk);
      check_eq("phase_err_sticky", 32'(phase_err), 1);
`else
      check_eq("phase_err_off", 32'(phase_err), 0);
      repeat (5) @(negedge clk);
      check_eq("phase_err_off_late", 32'(phase_err), 0);
`endif
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("phase_err_rst", 32'(phase_err), 0);
      check_eq("final_rst_code", 32'(out_if.code), 0);
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
